// File: rtl/tdm_scan_pkg.sv
// ---------------------------------------------------------------------------
// tdm_scan_pkg
// Shared constants for the TDM scan multiplexer:
//   - FSM state encoding (IDLE / MANUAL / SCAN)
//   - mode input encoding (manual / auto-scan)
//   - helper to size the dwell counter from the DWELL parameter
// No ports; imported by tdm_next_ch and tdm_scan_mux.
// ---------------------------------------------------------------------------
package tdm_scan_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_MANUAL = 2'd1;
   localparam logic [1:0] ST_SCAN   = 2'd2;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Bits needed to hold the values 0..dwell, i.e. ceil(log2(dwell+1)).
   function automatic int cnt_width(input int dwell);
      return $clog2(dwell + 1);
   endfunction

endpackage

// File: rtl/tdm_next_ch.sv
// ---------------------------------------------------------------------------
// tdm_next_ch
// Combinational channel finder for the scan pointer.
// Ports:
//   ch_mask   [NUM_CH-1:0] in  : 1 = channel takes part in the scan
//   cur_ch    [SEL_W-1:0]  in  : channel currently presented
//   next_ch   [SEL_W-1:0]  out : next higher unmasked index, wrapping to
//                                the lowest unmasked index
//   lowest_ch [SEL_W-1:0]  out : lowest unmasked index (0 if none)
//   any_set                out : at least one channel is unmasked
// ---------------------------------------------------------------------------
module tdm_next_ch
   import tdm_scan_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [SEL_W-1:0]  cur_ch,
   output logic [SEL_W-1:0]  next_ch,
   output logic [SEL_W-1:0]  lowest_ch,
   output logic              any_set
);

   logic found_lo;
   logic found_nx;

   // Priority search from index 0 upward: the first hit is the lowest
   // unmasked channel, the first hit above cur_ch is the successor.
   always_comb begin
      lowest_ch = '0;
      next_ch   = '0;
      found_lo  = 1'b0;
      found_nx  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_mask[i] && !found_lo) begin
            lowest_ch = SEL_W'(i);
            found_lo  = 1'b1;
         end
         if (ch_mask[i] && !found_nx && (SEL_W'(i) > cur_ch)) begin
            next_ch  = SEL_W'(i);
            found_nx = 1'b1;
         end
      end
      // Nothing above the current channel: wrap with no gap cycle.
      if (!found_nx) begin
         next_ch = lowest_ch;
      end
   end

   assign any_set = |ch_mask;

endmodule

// File: rtl/tdm_scan_mux.sv
// ---------------------------------------------------------------------------
// tdm_scan_mux
// Time-division multiplexer selecting one of NUM_CH channels, either by a
// manual select or by scanning the unmasked channels, each held for DWELL
// cycles. All outputs are registered one clock after the sampled inputs.
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : asynchronous active-high reset
//   en           in  : run enable (0 returns to IDLE)
//   mode         in  : 0 = manual select, 1 = auto-scan
//   sel_in       in  : manual channel select [SEL_W-1:0]
//   ch_mask      in  : scan inclusion mask [NUM_CH-1:0]
//   data_in      in  : packed channels, channel i at [i*DATA_W +: DATA_W]
//   data_out     out : registered selected channel data [DATA_W-1:0]
//   sel_out      out : channel index shown on data_out [SEL_W-1:0]
//   valid_out    out : data_out / sel_out are meaningful
//   frame_start  out : pulse on the first dwell cycle of the lowest
//                      unmasked channel while scanning
// ---------------------------------------------------------------------------
module tdm_scan_mux
   import tdm_scan_pkg::*;
#(
   parameter  int NUM_CH = 8,
   parameter  int DATA_W = 1,
   parameter  int DWELL  = 1,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel_in,
   input  logic [NUM_CH-1:0]        ch_mask,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   output logic [DATA_W-1:0]        data_out,
   output logic [SEL_W-1:0]         sel_out,
   output logic                     valid_out,
   output logic                     frame_start
);

   localparam int              CNT_W      = cnt_width(DWELL);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   // Selects channel idx from the packed bus; out-of-range gives zero.
   function automatic logic [DATA_W-1:0] pick_ch(
      input logic [NUM_CH*DATA_W-1:0] bus,
      input logic [SEL_W-1:0]         idx
   );
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx == SEL_W'(i)) begin
            r = bus[i*DATA_W +: DATA_W];
         end
      end
      return r;
   endfunction

   // True when idx names an existing channel (matters for non-power-of-2
   // channel counts, where sel_in can exceed NUM_CH-1).
   function automatic logic sel_ok(input logic [SEL_W-1:0] idx);
      return ({1'b0, idx} < (SEL_W+1)'(NUM_CH));
   endfunction

   logic [1:0]        state_r, state_nx;
   logic [SEL_W-1:0]  ptr_r, ptr_nx;
   logic [CNT_W-1:0]  cnt_r, cnt_nx;

   logic [SEL_W-1:0]  next_ch;
   logic [SEL_W-1:0]  lowest_ch;
   logic              any_set;

   logic [DATA_W-1:0] data_p1, data_nx;
   logic [SEL_W-1:0]  sel_p1, sel_nx;
   logic              vld_p1, vld_nx;
   logic              frame_p1, frame_nx;

   tdm_next_ch #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_next_ch (
      .ch_mask   (ch_mask),
      .cur_ch    (ptr_r),
      .next_ch   (next_ch),
      .lowest_ch (lowest_ch),
      .any_set   (any_set)
   );

   // Stage p0: next state from the sampled control inputs.
   // Entering SCAN needs at least one unmasked channel, otherwise the
   // block would scan nothing; it falls back to IDLE instead.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               if (mode == MODE_MANUAL) begin
                  state_nx = ST_MANUAL;
               end else if (any_set) begin
                  state_nx = ST_SCAN;
               end
            end
         end
         ST_MANUAL: begin
            if (!en) begin
               state_nx = ST_IDLE;
            end else if (mode == MODE_SCAN) begin
               state_nx = any_set ? ST_SCAN : ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (!en) begin
               state_nx = ST_IDLE;
            end else if (mode == MODE_MANUAL) begin
               state_nx = ST_MANUAL;
            end else if (!any_set) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Scan pointer and dwell counter. cnt_r counts the cycles the current
   // channel has already been shown beyond its first, so it tops out at
   // DWELL-1 and cannot overflow. A channel that gets masked is left on
   // the next clock regardless of how far its dwell has run.
   always_comb begin
      ptr_nx = ptr_r;
      cnt_nx = cnt_r;
      if (state_nx == ST_SCAN) begin
         if (state_r != ST_SCAN) begin
            ptr_nx = lowest_ch;
            cnt_nx = '0;
         end else if (!ch_mask[ptr_r] || (cnt_r == DWELL_LAST)) begin
            ptr_nx = next_ch;
            cnt_nx = '0;
         end else begin
            cnt_nx = cnt_r + CNT_W'(1);
         end
      end
   end

   // Output values for the coming cycle, derived from the next state so
   // that data appears exactly one clock after the inputs were sampled.
   always_comb begin
      data_nx  = data_p1;
      sel_nx   = sel_p1;
      vld_nx   = 1'b0;
      frame_nx = 1'b0;
      case (state_nx)
         ST_MANUAL: begin
            if (sel_ok(sel_in)) begin
               data_nx = pick_ch(data_in, sel_in);
               sel_nx  = sel_in;
               vld_nx  = 1'b1;
            end else begin
               data_nx = '0;
            end
         end
         ST_SCAN: begin
            data_nx  = pick_ch(data_in, ptr_nx);
            sel_nx   = ptr_nx;
            vld_nx   = 1'b1;
            frame_nx = (ptr_nx == lowest_ch) && (cnt_nx == '0);
         end
         default: ;
      endcase
   end

   // Stage p1: registered state, scan position and outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         ptr_r    <= '0;
         cnt_r    <= '0;
         data_p1  <= '0;
         sel_p1   <= '0;
         vld_p1   <= 1'b0;
         frame_p1 <= 1'b0;
      end else begin
         state_r  <= state_nx;
         ptr_r    <= ptr_nx;
         cnt_r    <= cnt_nx;
         data_p1  <= data_nx;
         sel_p1   <= sel_nx;
         vld_p1   <= vld_nx;
         frame_p1 <= frame_nx;
      end
   end

   assign data_out    = data_p1;
   assign sel_out     = sel_p1;
   assign valid_out   = vld_p1;
   assign frame_start = frame_p1;

endmodule

// File: doc/tdm_scan_mux.md
TDM_SCAN_MUX -- requirements
Module: tdm_scan_mux

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8, meaning the number of input channels (2..64).
REQ-002 The block SHALL have parameter DATA_W, default 1, meaning the width of each channel in bits.
REQ-003 The block SHALL have parameter DWELL, default 1, meaning the number of cycles each channel is held in scan mode (1..256).
REQ-004 The block SHALL derive localparam SEL_W = $clog2(NUM_CH); it is not user-settable.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: run enable.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 selects manual, 1 selects auto-scan.
REQ-009 The block SHALL have port sel_in, input, SEL_W bits: the manual channel select.
REQ-010 The block SHALL have port ch_mask, input, NUM_CH bits: 1 = channel included in the scan.
REQ-011 The block SHALL have port data_in, input, NUM_CH*DATA_W bits: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-012 The block SHALL have port data_out, output, DATA_W bits: the registered selected data.
REQ-013 The block SHALL have port sel_out, output, SEL_W bits: the channel index presented on data_out.
REQ-014 The block SHALL have port valid_out, output, 1 bit: data_out and sel_out are meaningful.
REQ-015 The block SHALL have port frame_start, output, 1 bit: a one-cycle pulse when the scan presents the lowest unmasked channel.

Function
REQ-016 The block SHALL implement states IDLE, MANUAL and SCAN, held in one state register.
REQ-017 The state transitions SHALL be:
- IDLE->MANUAL when en=1 and mode=0.
- IDLE->SCAN when en=1, mode=1 and ch_mask is non-zero.
- MANUAL/SCAN->IDLE when en=0.
- MANUAL<->SCAN on a change of mode.
REQ-018 All outputs SHALL be registered, with latency of exactly one clock from the sampled inputs to data_out, sel_out and valid_out.
REQ-019 In MANUAL, data_out SHALL equal channel sel_in, sel_out SHALL equal sel_in, and valid_out SHALL be 1; ch_mask is ignored.
REQ-020 In MANUAL with sel_in >= NUM_CH, data_out and valid_out SHALL be 0 and sel_out SHALL hold its previous value.
REQ-021 In SCAN, a dwell counter SHALL hold each unmasked channel for exactly DWELL cycles, then advance to the next higher unmasked index.
REQ-022 The scan pointer SHALL wrap from the highest unmasked index to the lowest unmasked index with no gap cycle.
REQ-023 Entering SCAN from IDLE or MANUAL SHALL start at the lowest unmasked channel with the dwell counter cleared.
REQ-024 frame_start SHALL be 1 only on the first dwell cycle of the lowest unmasked channel, and 0 in every other state.
REQ-025 If the currently scanned channel becomes masked, the pointer SHALL advance on the next clock regardless of the dwell count.
REQ-026 If ch_mask becomes all-zero in SCAN, the block SHALL enter IDLE on the next clock.
REQ-027 With a single unmasked channel, the block SHALL present that channel continuously and pulse frame_start every DWELL cycles.
REQ-028 In IDLE, data_out and sel_out SHALL hold their last values, valid_out SHALL be 0, and frame_start SHALL be 0.
REQ-029 The dwell counter SHALL be ceil(log2(DWELL+1)) bits wide and SHALL never overflow; DWELL=1 advances every cycle.

Reset
REQ-030 Asserting rst SHALL asynchronously force the state to IDLE and clear data_out, sel_out, valid_out, frame_start, the scan pointer and the dwell counter, all to 0.
REQ-031 Reset asserted mid-scan SHALL abandon the current dwell; after release, the scan SHALL restart per REQ-023.
REQ-032 The first active edge after rst deasserts SHALL be able to leave IDLE.

Structure
REQ-033 Package tdm_scan_pkg SHALL hold the state encoding (IDLE=2'd0, MANUAL=2'd1, SCAN=2'd2) and the mode constants MODE_MANUAL=0 and MODE_SCAN=1.
REQ-034 A combinational sub-module tdm_next_ch SHALL compute, from ch_mask and the current index, the next unmasked index with wrap-around, the lowest unmasked index, and an any-set flag.

Verification
REQ-035 The bench SHALL cover these directed scenarios, with NUM_CH=8, DATA_W=1, data_in=8'b0000_1010:
- Manual: sel_in stepped 0..7 every 10 time units -> one cycle later data_out = 0,1,0,1,0,0,0,0 with valid_out=1.
- Scan, DWELL=1, ch_mask=8'hFF -> sel_out cycles 0..7 then 0; data_out follows the pattern; frame_start is high only when sel_out=0.
- Scan, DWELL=3, ch_mask=8'b0000_1010 -> sel_out = 1,1,1,3,3,3,1...; frame_start fires every 6 cycles.
- Channel 3 masked mid-dwell -> next clock sel_out=1; ch_mask set to 0 -> next clock valid_out=0 and the state is IDLE.
- rst asserted mid-scan (asynchronously, between edges) -> all outputs 0 immediately; after release with en=1, mode=1, the scan resumes at the lowest unmasked channel.
- Manual sel_in=3'b111 with NUM_CH=6 -> data_out=0, valid_out=0.
